// File: rtl/password_entry_ctrl.sv
// -----------------------------------------------------------------------------
// password_entry_ctrl
//
// Initiator side of the password check interface. Serial keypad bits are
// shifted MSB-first into a PW_WIDTH-bit code. A submit with a complete entry
// presents the code to the checker with a one-cycle enter strobe. The block
// then waits up to RESP_TIMEOUT cycles for access_granted / error, and reports
// the outcome as a one-cycle pulse. A timeout from the checker latches a
// permanent lockout that only reset clears.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   key_valid       strobe: key_bit carries a newly entered bit
//   key_bit         entered bit value
//   key_clear       strobe: discard the partial entry
//   key_submit      strobe: send the entry to the checker
//   access_granted  checker response: code correct
//   error           checker response: code wrong
//   timeout         checker response: lockout (level, sticky)
//   password        code presented to the checker (the shift register)
//   enter           one-cycle strobe to the checker
//   bit_count       number of bits entered so far
//   busy            high while a code is in flight (SEND, WAIT, DONE)
//   granted_p       one-cycle pulse: access granted
//   denied_p        one-cycle pulse: access denied
//   noresp_p        one-cycle pulse: checker silent for RESP_TIMEOUT cycles
//   short_p         one-cycle pulse: submit with an incomplete entry
//   fail_count      denials since the last grant, saturating at 3
//   locked          permanent lockout indicator
// -----------------------------------------------------------------------------
module password_entry_ctrl #(
  parameter int unsigned PW_WIDTH     = 4,
  parameter int unsigned RESP_TIMEOUT = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              key_valid,
  input  logic                              key_bit,
  input  logic                              key_clear,
  input  logic                              key_submit,
  input  logic                              access_granted,
  input  logic                              error,
  input  logic                              timeout,
  output logic [PW_WIDTH-1:0]               password,
  output logic                              enter,
  output logic [$clog2(PW_WIDTH+1)-1:0]     bit_count,
  output logic                              busy,
  output logic                              granted_p,
  output logic                              denied_p,
  output logic                              noresp_p,
  output logic                              short_p,
  output logic [1:0]                        fail_count,
  output logic                              locked
);

  localparam int unsigned CntW  = $clog2(PW_WIDTH + 1);
  localparam int unsigned WaitW = $clog2(RESP_TIMEOUT);

  localparam logic [CntW-1:0]  CntFull = CntW'(PW_WIDTH);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(RESP_TIMEOUT - 1);

  localparam logic [2:0] StCollect = 3'd0;
  localparam logic [2:0] StSend    = 3'd1;
  localparam logic [2:0] StWait    = 3'd2;
  localparam logic [2:0] StDone    = 3'd3;
  localparam logic [2:0] StLocked  = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [PW_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [1:0]          fail_q, fail_d;
  logic                enter_q, enter_d;
  logic                busy_q, busy_d;
  logic                locked_q, locked_d;
  logic                granted_q, granted_d;
  logic                denied_q, denied_d;
  logic                noresp_q, noresp_d;
  logic                short_q, short_d;

  logic entry_full;
  assign entry_full = (cnt_q == CntFull);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    fail_d    = fail_q;
    enter_d   = 1'b0;
    granted_d = 1'b0;
    denied_d  = 1'b0;
    noresp_d  = 1'b0;
    short_d   = 1'b0;

    if (timeout) begin
      // Lockout overrides every state and every key; entry is left as-is.
      state_d = StLocked;
    end else begin
      case (state_q)
        StCollect: begin
          if (key_clear) begin
            shift_d = '0;
            cnt_d   = '0;
          end else if (key_submit) begin
            if (entry_full) begin
              state_d = StSend;
              enter_d = 1'b1;
            end else begin
              short_d = 1'b1;
            end
          end else if (key_valid && !entry_full) begin
            shift_d = {shift_q[PW_WIDTH-2:0], key_bit};
            cnt_d   = cnt_q + CntW'(1);
          end
        end

        StSend: begin
          state_d = StWait;
          wait_d  = '0;
        end

        StWait: begin
          if (access_granted) begin
            state_d   = StDone;
            granted_d = 1'b1;
            fail_d    = 2'd0;
          end else if (error) begin
            state_d  = StDone;
            denied_d = 1'b1;
            if (fail_q != 2'd3) begin
              fail_d = fail_q + 2'd1;
            end
          end else if (wait_q == WaitMax) begin
            state_d  = StDone;
            noresp_d = 1'b1;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end

        StDone: begin
          state_d = StCollect;
          shift_d = '0;
          cnt_d   = '0;
        end

        StLocked: begin
          state_d = StLocked;
        end

        default: begin
          state_d = StCollect;
        end
      endcase
    end

    // Status flags are registered copies of the next-state decode so they
    // line up with the state they describe.
    busy_d   = (state_d == StSend) || (state_d == StWait) || (state_d == StDone);
    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StCollect;
      shift_q   <= '0;
      cnt_q     <= '0;
      wait_q    <= '0;
      fail_q    <= 2'd0;
      enter_q   <= 1'b0;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
      granted_q <= 1'b0;
      denied_q  <= 1'b0;
      noresp_q  <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      fail_q    <= fail_d;
      enter_q   <= enter_d;
      busy_q    <= busy_d;
      locked_q  <= locked_d;
      granted_q <= granted_d;
      denied_q  <= denied_d;
      noresp_q  <= noresp_d;
      short_q   <= short_d;
    end
  end

  assign password   = shift_q;
  assign bit_count  = cnt_q;
  assign fail_count = fail_q;
  assign enter      = enter_q;
  assign busy       = busy_q;
  assign locked     = locked_q;
  assign granted_p  = granted_q;
  assign denied_p   = denied_q;
  assign noresp_p   = noresp_q;
  assign short_p    = short_q;

endmodule
